clk_divider_multi: RTL and testbench

CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

---
 rtl/clk_divider_pkg.sv | 9 +
 rtl/clk_div_channel.sv | 103 ++++++++++
 rtl/clk_divider_multi.sv | 67 ++++++
 tb/tb_clk_divider_multi.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// Shared constants for the multi-channel clock divider: mode encoding and
// the divisor every channel comes out of reset with.
package clk_divider_pkg;

  localparam logic MODE_TOGGLE     = 1'b0;
  localparam logic MODE_TICK       = 1'b1;
  localparam int   DEFAULT_DIV_VAL = 160000;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active divisor, registered clk_out/tick.
// CLKDIV_SYNC_LOAD_EN defers divisor writes to the next terminal count.
module clk_div_channel
  import clk_divider_pkg::*;
#(
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             term;
  logic             level;

`ifdef CLKDIV_SYNC_LOAD_EN
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
`endif

  // A counter left above a shrunk divisor simply wraps through zero.
  assign term = en && (cnt_q == div_q);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = term;
    level  = clk_out_q;
    if (term) begin
      cnt_d = '0;
      level = ~clk_out_q;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`ifdef CLKDIV_SYNC_LOAD_EN
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    if (pend_q && (term || !en)) begin
      div_d  = pend_val_q;
      pend_d = 1'b0;
    end
    if (wr) begin
      if (!en) begin
        div_d  = wr_val;
        pend_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_val_d = wr_val;
      end
    end
`else
    // Immediate load restarts the period but keeps the output level.
    if (wr) begin
      div_d = wr_val;
      cnt_d = '0;
      level = clk_out_q;
    end
`endif
    clk_out_d = (mode == MODE_TOGGLE) ? level : 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= DIV_RST;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

`ifdef CLKDIV_SYNC_LOAD_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_val_q <= DIV_RST;
    end else begin
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
    end
  end
`endif

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent clock dividers sharing one divisor write port.
// Define CLKDIV_SYNC_LOAD_EN for glitch-free divisor updates at period end.
module clk_divider_multi
  import clk_divider_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 27,
  parameter int  DEFAULT_DIV = DEFAULT_DIV_VAL,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic              div_ack,
  output logic              div_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic ch_valid;
  logic div_ack_q, div_ack_d;
  logic div_err_q, div_err_d;

  assign ch_valid = (32'(div_ch) < 32'(NUM_CH));

  always_comb begin
    div_ack_d = div_wr && ch_valid;
    div_err_d = div_wr && !ch_valid;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_ack_q <= 1'b0;
      div_err_q <= 1'b0;
    end else begin
      div_ack_q <= div_ack_d;
      div_err_q <= div_err_d;
    end
  end

  assign div_ack = div_ack_q;
  assign div_err = div_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_sel;
    assign wr_sel = div_wr && ch_valid && (div_ch == CH_W'(gi));

    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .en     (en[gi]),
      .mode   (mode[gi]),
      .wr     (wr_sel),
      .wr_val (div_val),
      .clk_out(clk_out[gi]),
      .tick   (tick[gi])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench: per-cycle comparison against a behavioural model plus
// directed timing checks with hand-computed periods.
module tb_clk_divider_multi;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int DEF = 3;
  localparam int MOD = 1 << CW;

  logic           clk_in = 1'b0;
  logic           rst_n  = 1'b0;
  logic [NCH-1:0] en     = 5'b00101;
  logic [NCH-1:0] mode   = '0;
  logic           div_wr = 1'b0;
  logic [2:0]     div_ch = '0;
  logic [CW-1:0]  div_val = '0;
  logic           div_ack, div_err;
  logic [NCH-1:0] clk_out, tick;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  clk_divider_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DEF)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .mode(mode),
    .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
    .div_ack(div_ack), .div_err(div_err), .clk_out(clk_out), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model: position within the period, divisor, pending divisor.
  int m_pos[NCH], m_div[NCH], m_pval[NCH];
  bit m_clk[NCH], m_tick[NCH], m_pend[NCH];
  bit m_ack, m_err, m_ok, m_tc, m_wr, m_lvl;
  logic [NCH-1:0] exp_clk, exp_tick;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_pos[c] = 0; m_div[c] = DEF; m_pval[c] = DEF;
        m_clk[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
      end
      m_ack = 0; m_err = 0;
    end else begin
      m_ok  = div_wr && (int'(div_ch) < NCH);
      m_ack = m_ok;
      m_err = div_wr && !m_ok;
      for (int c = 0; c < NCH; c++) begin
        m_tc = en[c] && (m_pos[c] == m_div[c]);
        m_wr = m_ok && (int'(div_ch) == c);
        m_tick[c] = m_tc;
        m_lvl = m_tc ? !m_clk[c] : m_clk[c];
        if (m_tc) m_pos[c] = 0;
        else if (en[c]) m_pos[c] = (m_pos[c] + 1) % MOD;
`ifdef CLKDIV_SYNC_LOAD_EN
        if (m_pend[c] && (m_tc || !en[c])) begin
          m_div[c] = m_pval[c]; m_pend[c] = 0;
        end
        if (m_wr && !en[c]) begin
          m_div[c] = int'(div_val); m_pend[c] = 0;
        end else if (m_wr) begin
          m_pend[c] = 1; m_pval[c] = int'(div_val);
        end
`else
        if (m_wr) begin
          m_div[c] = int'(div_val); m_pos[c] = 0; m_lvl = m_clk[c];
        end
`endif
        m_clk[c] = mode[c] ? 1'b0 : m_lvl;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (chk_on) begin
      for (int c = 0; c < NCH; c++) begin
        exp_clk[c]  = m_clk[c];
        exp_tick[c] = m_tick[c];
      end
      check("model clk_out", int'(clk_out), int'(exp_clk));
      check("model tick", int'(tick), int'(exp_tick));
      check("model div_ack", int'(div_ack), int'(m_ack));
      check("model div_err", int'(div_err), int'(m_err));
    end
  end

  // Returns the number of negedges until tick[ch] is seen high.
  task automatic wait_tick(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (tick[ch] !== 1'b1 && n < 400);
    if (tick[ch] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_tick ch%0d: tick=0 after %0d cycles, required 1", ch, n);
    end
  endtask

  task automatic write_div(input int ch, input int val);
    div_wr = 1'b1; div_ch = 3'(ch); div_val = CW'(val);
  endtask

  int n, highs, last_rise;
  logic prev;

  initial begin
    @(negedge clk_in);
    chk_on = 1'b1;
    @(negedge clk_in);
    check("reset clk_out", int'(clk_out), 0);
    check("reset tick", int'(tick), 0);
    check("reset ack/err", int'({div_ack, div_err}), 0);
    rst_n = 1'b1;

    // Default divisor 3: tick every 4, clk_out period 8 at 50% duty.
    wait_tick(0, n); check("ch0 first tick", n, 4);
    wait_tick(0, n); check("ch0 tick period", n, 4);
    highs = 0; last_rise = -1; prev = clk_out[0];
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_in);
      if (i < 16 && clk_out[0]) highs++;
      if (clk_out[0] && !prev) begin
        if (last_rise >= 0) check("ch0 clk_out period", i - last_rise, 8);
        last_rise = i;
      end
      prev = clk_out[0];
    end
    check("ch0 duty highs/16", highs, 8);

    // ch1: divisor 0 in tick mode keeps tick high; en=0 freezes it.
    @(negedge clk_in); write_div(1, 0);
    @(negedge clk_in); div_wr = 1'b0;
    check("ch1 ack", int'(div_ack), 1);
    mode[1] = 1'b1; en[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      check("ch1 tick held", int'(tick[1]), 1);
      check("ch1 clk_out low", int'(clk_out[1]), 0);
    end
    en[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("ch1 tick disabled", int'(tick[1]), 0);
    end
    en[1] = 1'b1;
    @(negedge clk_in);
    check("ch1 tick resumed", int'(tick[1]), 1);

    // ch2: single write of 9 aligned to a tick.
    wait_tick(2, n);
    write_div(2, 9);
    @(negedge clk_in); div_wr = 1'b0;
    check("ch2 ack", int'(div_ack), 1);
    check("ch2 no err", int'(div_err), 0);
    wait_tick(2, n);
`ifdef CLKDIV_SYNC_LOAD_EN
    check("ch2 old period completes", n, 3);
`else
    check("ch2 restart after ack", n, 10);
`endif
    wait_tick(2, n); check("ch2 new period", n, 10);

    // ch2: two back-to-back writes, only the last value sticks.
    wait_tick(2, n);
    write_div(2, 7);
    @(negedge clk_in); write_div(2, 5);
    check("ch2 ack 1st", int'(div_ack), 1);
    @(negedge clk_in); div_wr = 1'b0;
    check("ch2 ack 2nd", int'(div_ack), 1);
    wait_tick(2, n);
`ifdef CLKDIV_SYNC_LOAD_EN
    check("ch2 boundary kept", n, 8);
`else
    check("ch2 restart 2nd write", n, 6);
`endif
    wait_tick(2, n); check("ch2 last value period", n, 6);

    // Out-of-range channel is rejected and leaves timing alone.
    @(negedge clk_in); write_div(5, 1);
    @(negedge clk_in); div_wr = 1'b0;
    check("bad ch err", int'(div_err), 1);
    check("bad ch no ack", int'(div_ack), 0);
    wait_tick(0, n);
    wait_tick(0, n); check("ch0 period after bad write", n, 4);

    // Reset while a write is in flight (and one may be pending).
    @(negedge clk_in); write_div(0, 20);
    @(negedge clk_in); write_div(0, 30);
    #2 rst_n = 1'b0;
    #1;
    check("async reset clk_out", int'(clk_out), 0);
    check("async reset tick", int'(tick), 0);
    check("async reset ack/err", int'({div_ack, div_err}), 0);
    div_wr = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    check("no ack after reset", int'(div_ack), 0);
    wait_tick(0, n); check("ch0 default after reset", n, 3);
    wait_tick(0, n); check("ch0 default period", n, 4);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) mode = NCH'($urandom);
      div_wr  = ($urandom_range(0, 5) == 0);
      div_ch  = 3'($urandom_range(0, 7));
      div_val = CW'($urandom_range(0, 12));
    end
    @(negedge clk_in); div_wr = 1'b0;
    @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
